// File: rtl/riscv_hart_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// riscv_hart_fetch_scheduler
//
// Round-robin hart scheduler placed in front of the multithreaded prefetch
// buffer. It picks the hart that fetches next and holds that request stable
// until the buffer accepts it. It carries hart-ID tags alongside the IF, ID
// and EX stages, tracks per-hart control-flow blocking, and raises a boot
// flag until the first fetch is accepted.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   hart_en_i           per-hart enable mask (level)
//   block_set_i         per-hart pulse: unresolved branch/jump issued
//   block_clr_i         per-hart pulse: control flow resolved
//   halt_if_i           global fetch halt
//   fetch_valid_o       hart_fetch_o is a valid fetch request
//   fetch_ack_i         prefetch buffer accepted the current request
//   hart_fetch_o        hart selected for the next fetch
//   if_valid_i, id_ready_i, id_valid_i, ex_ready_i
//                       pipeline handshakes that move the hart tags
//   hart_id_IF_o/ID_o/EX_o  hart tag of the IF/ID/EX instruction
//   blocked_o           per-hart block state
//   is_boot_o           high from reset until the first accepted fetch
// ---------------------------------------------------------------------------
module riscv_hart_fetch_scheduler #(
  parameter int NUM_THREADS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_THREADS-1:0]       hart_en_i,
  input  logic [NUM_THREADS-1:0]       block_set_i,
  input  logic [NUM_THREADS-1:0]       block_clr_i,
  input  logic                         halt_if_i,
  output logic                         fetch_valid_o,
  input  logic                         fetch_ack_i,
  output logic [$clog2(NUM_THREADS)-1:0] hart_fetch_o,
  input  logic                         if_valid_i,
  input  logic                         id_ready_i,
  input  logic                         id_valid_i,
  input  logic                         ex_ready_i,
  output logic [$clog2(NUM_THREADS)-1:0] hart_id_IF_o,
  output logic [$clog2(NUM_THREADS)-1:0] hart_id_ID_o,
  output logic [$clog2(NUM_THREADS)-1:0] hart_id_EX_o,
  output logic [NUM_THREADS-1:0]       blocked_o,
  output logic                         is_boot_o
);

  localparam int THREAD_ADDR_WIDTH = $clog2(NUM_THREADS);

  typedef logic [THREAD_ADDR_WIDTH-1:0] hart_t;

  hart_t                  rr_ptr_q, rr_ptr_d;
  hart_t                  locked_hart_q, locked_hart_d;
  hart_t                  last_hart_q, last_hart_d;
  hart_t                  hart_if_q, hart_if_d;
  hart_t                  hart_id_q, hart_id_d;
  hart_t                  hart_ex_q, hart_ex_d;
  logic                   lock_q, lock_d;
  logic                   is_boot_q, is_boot_d;
  logic [NUM_THREADS-1:0] blocked_q, blocked_d;

  logic [NUM_THREADS-1:0] eligible;
  logic                   any_eligible;
  logic                   lock_live;
  logic                   rr_found;
  hart_t                  rr_pick;
  hart_t                  sel;
  logic                   fire;
  logic                   stall;

  assign eligible     = hart_en_i & ~blocked_q;
  assign any_eligible = |eligible;

  // Scan rr_ptr+1, rr_ptr+2, ... ; the hart_t-wide sum wraps modulo
  // NUM_THREADS because NUM_THREADS is a power of two. The final step
  // (i == NUM_THREADS) revisits rr_ptr itself, so a lone eligible hart
  // can still win back-to-back.
  always_comb begin
    rr_pick  = rr_ptr_q;
    rr_found = 1'b0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      if (!rr_found && eligible[rr_ptr_q + hart_t'(i)]) begin
        rr_pick  = rr_ptr_q + hart_t'(i);
        rr_found = 1'b1;
      end
    end
  end

  // A lock whose hart has gone ineligible is ignored so a fresh round-robin
  // choice is presented in the same cycle.
  assign lock_live = lock_q & eligible[locked_hart_q];

  always_comb begin
    sel = rr_pick;
    if (!any_eligible) begin
      sel = last_hart_q;
    end else if (lock_live) begin
      sel = locked_hart_q;
    end
  end

  // Gating with rst makes the request drop the moment reset is asserted,
  // without waiting for the flops to settle through a clock edge.
  assign fetch_valid_o = ~rst & ~halt_if_i & any_eligible;
  assign hart_fetch_o  = rst ? hart_t'(0) : sel;

  assign fire  = fetch_valid_o & fetch_ack_i;
  assign stall = fetch_valid_o & ~fetch_ack_i;

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    lock_d        = lock_q;
    locked_hart_d = locked_hart_q;
    is_boot_d     = is_boot_q;
    hart_if_d     = hart_if_q;
    last_hart_d   = any_eligible ? sel : last_hart_q;
    blocked_d     = (blocked_q & ~block_clr_i) | block_set_i;

    if (fire) begin
      rr_ptr_d  = sel;
      lock_d    = 1'b0;
      is_boot_d = 1'b0;
      hart_if_d = sel;
    end else if (stall) begin
      lock_d        = 1'b1;
      locked_hart_d = sel;
    end else if (!halt_if_i && lock_q && !eligible[locked_hart_q]) begin
      lock_d = 1'b0;
    end

    // Tag shift: each stage takes its predecessor's pre-edge value.
    hart_id_d = (if_valid_i & id_ready_i) ? hart_if_q : hart_id_q;
    hart_ex_d = (id_valid_i & ex_ready_i) ? hart_id_q : hart_ex_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q      <= hart_t'(NUM_THREADS - 1);
      lock_q        <= 1'b0;
      locked_hart_q <= '0;
      last_hart_q   <= '0;
      is_boot_q     <= 1'b1;
      blocked_q     <= '0;
      hart_if_q     <= '0;
      hart_id_q     <= '0;
      hart_ex_q     <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      locked_hart_q <= locked_hart_d;
      last_hart_q   <= last_hart_d;
      is_boot_q     <= is_boot_d;
      blocked_q     <= blocked_d;
      hart_if_q     <= hart_if_d;
      hart_id_q     <= hart_id_d;
      hart_ex_q     <= hart_ex_d;
    end
  end

  assign hart_id_IF_o = hart_if_q;
  assign hart_id_ID_o = hart_id_q;
  assign hart_id_EX_o = hart_ex_q;
  assign blocked_o    = blocked_q;
  assign is_boot_o    = is_boot_q;

endmodule
